// File: rtl/dr_alu_seq_if.sv
// Dual-rail ALU bus: producer-side operands and opcode, consumer-side
// result/flags, and the two four-phase acknowledge wires.
interface dr_alu_seq_if #(
    parameter int W     = 4,
    parameter int CNT_W = 8
);
    logic [2*W-1:0]   a;
    logic [2*W-1:0]   b;
    logic [3:0]       opr;
    logic             in_ack;
    logic [2*W-1:0]   soma;
    logic [1:0]       of;
    logic [1:0]       neg;
    logic [1:0]       zero;
    logic             out_ack;
    logic             err;
    logic [CNT_W-1:0] txn_cnt;

    // Environment side: drives operands and consumer acknowledge
    modport master (
        output a, b, opr, out_ack,
        input  in_ack, soma, of, neg, zero, err, txn_cnt
    );

    // ALU side
    modport slave (
        input  a, b, opr, out_ack,
        output in_ack, soma, of, neg, zero, err, txn_cnt
    );
endinterface

// File: rtl/dr_alu_seq.sv
// Clocked dual-rail ALU: filters dual-rail input wavefronts, computes
// add/sub/and/xor and returns a dual-rail result with a four-phase handshake.
module dr_alu_seq #(
    parameter int W      = 4,
    parameter int STABLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic         clk,
    input  logic         rst,
    dr_alu_seq_if.slave  bus
);
    localparam int          NPAIR    = 2 * W + 2;
    localparam logic [3:0]  STABLE_C = 4'(STABLE);

    typedef enum logic [1:0] {
        S_NULL = 2'd0,
        S_CALC = 2'd1,
        S_DATA = 2'd2,
        S_RTZ  = 2'd3
    } state_t;

    // Logical value of a dual-rail word: the "true" rail of each pair
    function automatic logic [W-1:0] dr_dec(input logic [2*W-1:0] x);
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) begin
            v[i] = x[2*i+1];
        end
        return v;
    endfunction

    // Dual-rail encoding of a logical word (1 -> 10, 0 -> 01)
    function automatic logic [2*W-1:0] dr_enc(input logic [W-1:0] v);
        logic [2*W-1:0] x;
        for (int i = 0; i < W; i++) begin
            x[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
        end
        return x;
    endfunction

    // Dual-rail encoding of a single flag bit
    function automatic logic [1:0] dr_enc1(input logic v);
        return v ? 2'b10 : 2'b01;
    endfunction

    state_t             state_q;
    logic [3:0]         stab_q;
    logic [3:0]         stab_d;
    logic [4*W+3:0]     prev_q;
    logic [W-1:0]       av_q;
    logic [W-1:0]       bv_q;
    logic [1:0]         op_q;
    logic [W-1:0]       res_q;
    logic [W-1:0]       res_d;
    logic               ovf_q;
    logic               ovf_d;
    logic [2*W-1:0]     soma_q;
    logic [1:0]         of_q;
    logic [1:0]         neg_q;
    logic [1:0]         zero_q;
    logic               in_ack_q;
    logic               err_q;
    logic [CNT_W-1:0]   txn_q;

    logic [4*W+3:0]     in_word_s;
    logic               in_complete_s;
    logic               in_null_s;
    logic               in_illegal_s;

    assign in_word_s = {bus.a, bus.b, bus.opr};

    // Classify the current input word as complete, null and/or illegal
    always_comb begin
        in_complete_s = 1'b1;
        in_null_s     = 1'b1;
        in_illegal_s  = 1'b0;
        for (int i = 0; i < NPAIR; i++) begin
            in_complete_s = in_complete_s & (^in_word_s[2*i +: 2]);
            in_null_s     = in_null_s & ~(|in_word_s[2*i +: 2]);
            in_illegal_s  = in_illegal_s | (&in_word_s[2*i +: 2]);
        end
    end

    // Stability counter next value: an illegal pair always restarts filtering
    always_comb begin
        stab_d = 4'd0;
        if (in_illegal_s) begin
            stab_d = 4'd0;
        end else if (in_complete_s && (in_word_s == prev_q)) begin
            stab_d = (stab_q == 4'd15) ? stab_q : (stab_q + 4'd1);
        end else if (in_complete_s) begin
            stab_d = 4'd1;
        end else begin
            stab_d = 4'd0;
        end
    end

    // ALU datapath on the captured logical operands; carry-out is dropped
    always_comb begin
        res_d = {W{1'b0}};
        ovf_d = 1'b0;
        case (op_q)
            2'd0: begin
                res_d = av_q + bv_q;
                ovf_d = (av_q[W-1] == bv_q[W-1]) && (res_d[W-1] != av_q[W-1]);
            end
            2'd1: begin
                res_d = av_q - bv_q;
                ovf_d = (av_q[W-1] != bv_q[W-1]) && (res_d[W-1] != av_q[W-1]);
            end
            2'd2: begin
                res_d = av_q & bv_q;
                ovf_d = 1'b0;
            end
            2'd3: begin
                res_d = av_q ^ bv_q;
                ovf_d = 1'b0;
            end
            default: begin
                res_d = {W{1'b0}};
                ovf_d = 1'b0;
            end
        endcase
    end

    // Handshake FSM with capture, result registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_NULL;
            stab_q   <= 4'd0;
            prev_q   <= {(4*W+4){1'b0}};
            av_q     <= {W{1'b0}};
            bv_q     <= {W{1'b0}};
            op_q     <= 2'd0;
            res_q    <= {W{1'b0}};
            ovf_q    <= 1'b0;
            soma_q   <= {(2*W){1'b0}};
            of_q     <= 2'b00;
            neg_q    <= 2'b00;
            zero_q   <= 2'b00;
            in_ack_q <= 1'b0;
            err_q    <= 1'b0;
            txn_q    <= {CNT_W{1'b0}};
        end else begin
            prev_q <= in_word_s;
            err_q  <= err_q | in_illegal_s;
            case (state_q)
                S_NULL: begin
                    soma_q   <= {(2*W){1'b0}};
                    of_q     <= 2'b00;
                    neg_q    <= 2'b00;
                    zero_q   <= 2'b00;
                    in_ack_q <= 1'b0;
                    if (stab_d == STABLE_C) begin
                        av_q    <= dr_dec(bus.a);
                        bv_q    <= dr_dec(bus.b);
                        op_q    <= {bus.opr[3], bus.opr[1]};
                        stab_q  <= 4'd0;
                        state_q <= S_CALC;
                    end else begin
                        stab_q  <= stab_d;
                    end
                end
                S_CALC: begin
                    res_q   <= res_d;
                    ovf_q   <= ovf_d;
                    state_q <= S_DATA;
                end
                S_DATA: begin
                    // First cycle presents DATA; out_ack only counts afterwards
                    if (!in_ack_q) begin
                        soma_q   <= dr_enc(res_q);
                        of_q     <= dr_enc1(ovf_q);
                        neg_q    <= dr_enc1(res_q[W-1]);
                        zero_q   <= dr_enc1(res_q == {W{1'b0}});
                        in_ack_q <= 1'b1;
                    end else if (bus.out_ack) begin
                        soma_q   <= {(2*W){1'b0}};
                        of_q     <= 2'b00;
                        neg_q    <= 2'b00;
                        zero_q   <= 2'b00;
                        txn_q    <= txn_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        state_q  <= S_RTZ;
                    end else begin
                        state_q  <= S_DATA;
                    end
                end
                S_RTZ: begin
                    if (in_null_s && !bus.out_ack) begin
                        in_ack_q <= 1'b0;
                        stab_q   <= 4'd0;
                        state_q  <= S_NULL;
                    end else begin
                        state_q  <= S_RTZ;
                    end
                end
                default: begin
                    state_q  <= S_NULL;
                    stab_q   <= 4'd0;
                    in_ack_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.soma    = soma_q;
    assign bus.of      = of_q;
    assign bus.neg     = neg_q;
    assign bus.zero    = zero_q;
    assign bus.in_ack  = in_ack_q;
    assign bus.err     = err_q;
    assign bus.txn_cnt = txn_q;
endmodule

// File: tb/tb_dr_alu_seq.sv
// Scoreboard bench for dr_alu_seq (W=4, STABLE=2, CNT_W=8).
module tb_dr_alu_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;

    dr_alu_seq_if #(.W(4), .CNT_W(8)) bus ();

    dr_alu_seq #(.W(4), .STABLE(2), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] soma;
        logic [1:0] of;
        logic [1:0] neg;
        logic [1:0] zero;
    } exp_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] opr;
        exp_t       e;
    } vec_t;

    vec_t vecs [7];
    exp_t sb_q [$];
    int   checks   = 0;
    int   failures = 0;
    int   exp_txn  = 0;
    logic ack_prev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [3:0] opr);
        bus.a   = a;
        bus.b   = b;
        bus.opr = opr;
    endtask

    // Full transaction: push expectation, hold word, check latency, handshake out
    task automatic run_txn(input int idx);
        sb_q.push_back(vecs[idx].e);
        @(negedge clk);
        drive(vecs[idx].a, vecs[idx].b, vecs[idx].opr);
        repeat (3) @(negedge clk);
        chk("lat_early_ack", {31'd0, bus.in_ack}, 32'd0);
        @(negedge clk);
        chk("lat_ack", {31'd0, bus.in_ack}, 32'd1);
        bus.out_ack = 1'b1;
        @(negedge clk);
        exp_txn++;
        chk("rtz_soma", {24'd0, bus.soma}, 32'd0);
        chk("rtz_in_ack", {31'd0, bus.in_ack}, 32'd1);
        chk("txn_cnt", {24'd0, bus.txn_cnt}, exp_txn);
        drive(8'd0, 8'd0, 4'd0);
        bus.out_ack = 1'b0;
        @(negedge clk);
        chk("null_in_ack", {31'd0, bus.in_ack}, 32'd0);
    endtask

    // Monitor: on every rising in_ack compare presented DATA with the queue head
    always @(negedge clk) begin
        exp_t e;
        if (bus.in_ack === 1'b1 && ack_prev === 1'b0) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected act=%b exp=none", bus.soma);
            end else begin
                e = sb_q.pop_front();
                chk("sb_soma", {24'd0, bus.soma}, {24'd0, e.soma});
                chk("sb_of",   {30'd0, bus.of},   {30'd0, e.of});
                chk("sb_neg",  {30'd0, bus.neg},  {30'd0, e.neg});
                chk("sb_zero", {30'd0, bus.zero}, {30'd0, e.zero});
            end
        end
        ack_prev = bus.in_ack;
    end

    initial begin
        // a, b, opr, soma, of, neg, zero
        vecs[0] = {8'b01011010, 8'b01011001, 4'b0101, 8'b01100110, 2'b01, 2'b01, 2'b01}; // 3+2=5
        vecs[1] = {8'b01101010, 8'b01010110, 4'b0101, 8'b10010101, 2'b10, 2'b10, 2'b01}; // 7+1=-8 ovf
        vecs[2] = {8'b01011010, 8'b01011010, 4'b0110, 8'b01010101, 2'b01, 2'b01, 2'b10}; // 3-3=0
        vecs[3] = {8'b10100101, 8'b10011001, 4'b1001, 8'b10010101, 2'b01, 2'b10, 2'b01}; // 1100&1010
        vecs[4] = {8'b10100101, 8'b10011001, 4'b1010, 8'b01101001, 2'b01, 2'b01, 2'b01}; // 1100^1010
        vecs[5] = {8'b10010101, 8'b01010110, 4'b0110, 8'b01101010, 2'b10, 2'b01, 2'b01}; // -8-1 ovf
        vecs[6] = {8'b01011001, 8'b01011010, 4'b0110, 8'b10101010, 2'b01, 2'b10, 2'b01}; // 2-3=-1

        drive(8'd0, 8'd0, 4'd0);
        bus.out_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_soma",   {24'd0, bus.soma}, 32'd0);
        chk("rst_flags",  {26'd0, bus.of, bus.neg, bus.zero}, 32'd0);
        chk("rst_in_ack", {31'd0, bus.in_ack}, 32'd0);
        chk("rst_err",    {31'd0, bus.err}, 32'd0);
        chk("rst_txn",    {24'd0, bus.txn_cnt}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_txn(i);
        end

        // Glitch filter: operand a changes value every cycle
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive((i % 2 == 0) ? 8'b01011010 : 8'b01011001, 8'b01011001, 4'b0101);
            chk("glitch_in_ack", {31'd0, bus.in_ack}, 32'd0);
        end
        @(negedge clk);
        drive(8'd0, 8'd0, 4'd0);
        repeat (4) @(negedge clk);
        chk("glitch_no_capture", {31'd0, bus.in_ack}, 32'd0);

        // Partial word: one pair of a still NULL
        drive(8'b01011000, 8'b01011001, 4'b0101);
        repeat (5) @(negedge clk);
        chk("partial_in_ack", {31'd0, bus.in_ack}, 32'd0);
        chk("partial_err",    {31'd0, bus.err}, 32'd0);
        drive(8'd0, 8'd0, 4'd0);
        repeat (2) @(negedge clk);

        // Illegal pair on b: sticky error, never captured
        drive(8'b01011010, 8'b01011011, 4'b0101);
        @(negedge clk);
        chk("illegal_err", {31'd0, bus.err}, 32'd1);
        repeat (4) @(negedge clk);
        chk("illegal_no_capture", {31'd0, bus.in_ack}, 32'd0);
        drive(8'd0, 8'd0, 4'd0);
        run_txn(0);
        chk("err_sticky", {31'd0, bus.err}, 32'd1);

        // Reset while DATA is presented, then recapture the held word
        sb_q.push_back(vecs[1].e);
        @(negedge clk);
        drive(vecs[1].a, vecs[1].b, vecs[1].opr);
        repeat (4) @(negedge clk);
        chk("pre_rst_in_ack", {31'd0, bus.in_ack}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_txn = 0;
        chk("mid_rst_soma",   {24'd0, bus.soma}, 32'd0);
        chk("mid_rst_flags",  {26'd0, bus.of, bus.neg, bus.zero}, 32'd0);
        chk("mid_rst_in_ack", {31'd0, bus.in_ack}, 32'd0);
        chk("mid_rst_txn",    {24'd0, bus.txn_cnt}, 32'd0);
        chk("mid_rst_err",    {31'd0, bus.err}, 32'd0);
        sb_q.push_back(vecs[1].e);
        repeat (3) @(negedge clk);
        chk("recap_early", {31'd0, bus.in_ack}, 32'd0);
        @(negedge clk);
        chk("recap_ack", {31'd0, bus.in_ack}, 32'd1);
        bus.out_ack = 1'b1;
        @(negedge clk);
        exp_txn++;
        chk("recap_txn", {24'd0, bus.txn_cnt}, exp_txn);
        drive(8'd0, 8'd0, 4'd0);
        bus.out_ack = 1'b0;
        @(negedge clk);
        chk("recap_null_ack", {31'd0, bus.in_ack}, 32'd0);

        @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
